// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/data memory handshake bundle for the multi-cycle controller
`timescale 1ns/1ps

interface multicycle_ctrl_if;
    logic [31:0] inst;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        input  inst,
        input  imem_ready,
        input  dmem_ready,
        output imem_req,
        output dmem_req,
        output dmem_we
    );

    modport slave (
        output inst,
        output imem_ready,
        output dmem_ready,
        input  imem_req,
        input  dmem_req,
        input  dmem_we
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with illegal-op and timeout traps
`timescale 1ns/1ps

module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_ctrl_if.master       bus,
    input  logic                    alu_zero,
    output logic                    ir_we,
    output logic [2:0]              imm_type,
    output logic                    alu_src_b,
    output logic [3:0]              alu_op,
    output logic                    rf_we,
    output logic                    wb_sel,
    output logic                    pc_we,
    output logic                    pc_sel,
    output logic                    retire,
    output logic                    trap,
    output logic [1:0]              trap_cause
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t        state, nstate;
    logic [1:0]    ncause;
    logic [CW-1:0] cnt;
    logic          imem_req_q, dmem_req_q, dmem_we_q;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r, is_i, is_lw, is_sw, is_br, legal;
    logic [2:0] dec_imm;
    logic [3:0] dec_op;
    logic       in_ops;
    logic       unused_inst_bits;

    assign opcode = bus.inst[6:0];
    assign f3     = bus.inst[14:12];
    assign f7     = bus.inst[31:25];
    assign unused_inst_bits = ^{bus.inst[24:15], bus.inst[11:7]};

    always_comb begin
        is_r  = (opcode == 7'b0110011) &&
                ((f7 == 7'b0000000) ||
                 ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
        is_i  = (opcode == 7'b0010011);
        is_lw = (opcode == 7'b0000011) && (f3 == 3'b010);
        is_sw = (opcode == 7'b0100011) && (f3 == 3'b010);
        is_br = (opcode == 7'b1100011) && ((f3 == 3'b000) || (f3 == 3'b001));
        legal = is_r | is_i | is_lw | is_sw | is_br;
    end

    always_comb begin
        dec_imm = 3'b000;
        if (is_i || is_lw) dec_imm = 3'b001;
        else if (is_sw)    dec_imm = 3'b010;
        else if (is_br)    dec_imm = 3'b011;
    end

    // funct3 drives the ALU for R/I; memory ops add, branches compare by subtracting
    always_comb begin
        dec_op = 4'd0;
        case (f3)
            3'b000:  dec_op = (is_r && bus.inst[30]) ? 4'd1 : 4'd0;
            3'b001:  dec_op = 4'd5;
            3'b010:  dec_op = 4'd8;
            3'b011:  dec_op = 4'd9;
            3'b100:  dec_op = 4'd4;
            3'b101:  dec_op = bus.inst[30] ? 4'd7 : 4'd6;
            3'b110:  dec_op = 4'd3;
            default: dec_op = 4'd2;
        endcase
        if (is_lw || is_sw) dec_op = 4'd0;
        if (is_br)          dec_op = 4'd1;
        if (!legal)         dec_op = 4'd0;
    end

    assign in_ops   = (state == S_DECODE) || (state == S_EXEC) ||
                      (state == S_MEM)    || (state == S_WB);
    assign imm_type = in_ops ? dec_imm : 3'b000;
    assign alu_op   = in_ops ? dec_op  : 4'd0;

    // Strobes qualified by same-cycle ready/alu_zero cannot be registered
    always_comb begin
        ir_we  = (state == S_FETCH) && bus.imem_ready;
        pc_we  = ((state == S_EXEC) && is_br) ||
                 ((state == S_MEM) && is_sw && bus.dmem_ready) ||
                 (state == S_WB);
        pc_sel = (state == S_EXEC) && is_br && (f3[0] ? !alu_zero : alu_zero);
    end
    assign retire = pc_we;

    always_comb begin
        nstate = state;
        ncause = 2'b00;
        case (state)
            S_IDLE:   nstate = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready)     nstate = S_DECODE;
                else if (cnt == CNT_LAST) begin
                    nstate = S_TRAP;
                    ncause = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal) nstate = S_EXEC;
                else begin
                    nstate = S_TRAP;
                    ncause = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_br)               nstate = S_FETCH;
                else if (is_lw || is_sw) nstate = S_MEM;
                else                     nstate = S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ready)     nstate = is_lw ? S_WB : S_FETCH;
                else if (cnt == CNT_LAST) begin
                    nstate = S_TRAP;
                    ncause = 2'b11;
                end
            end
            S_WB:     nstate = S_FETCH;
            S_TRAP:   nstate = S_TRAP;
            default:  nstate = S_IDLE;
        endcase
    end

    // Level outputs are registered from the next state so they are clean from the first cycle of each state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we      <= 1'b0;
            wb_sel     <= 1'b0;
            alu_src_b  <= 1'b0;
        end else begin
            state <= nstate;
            if ((nstate == state) && ((state == S_FETCH) || (state == S_MEM)))
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
            if ((nstate == S_TRAP) && (state != S_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= ncause;
            end
            imem_req_q <= (nstate == S_FETCH);
            dmem_req_q <= (nstate == S_MEM);
            dmem_we_q  <= (nstate == S_MEM) && is_sw;
            rf_we      <= (nstate == S_WB);
            wb_sel     <= (nstate == S_WB) && is_lw;
            alu_src_b  <= (nstate == S_EXEC) && (is_i || is_lw || is_sw);
        end
    end

    assign bus.imem_req = imem_req_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.dmem_we  = dmem_we_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed bench with a per-instruction trace model for multicycle_ctrl
`timescale 1ns/1ps

module tb_multicycle_ctrl;
    localparam int TMO = 16;
    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BR = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alu_zero = 1'b0;
    logic ir_we, alu_src_b, rf_we, wb_sel, pc_we, pc_sel, retire, trap;
    logic [2:0] imm_type;
    logic [3:0] alu_op;
    logic [1:0] trap_cause;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .alu_zero(alu_zero),
        .ir_we(ir_we), .imm_type(imm_type), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic [2:0] imm_type;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic       wb_sel;
        logic       pc_we;
        logic       pc_sel;
        logic       retire;
        logic       trap;
        logic [1:0] cause;
    } obs_t;

    int    n_tests = 0;
    int    n_fail = 0;
    obs_t  exp_cur;
    logic  exp_valid = 1'b0;
    string exp_name = "";
    int    since_retire = 0;
    int    last_cpi = 0;

    function automatic obs_t sample();
        obs_t o;
        o.imem_req = bus.imem_req;  o.ir_we = ir_we;      o.imm_type = imm_type;
        o.alu_src_b = alu_src_b;    o.alu_op = alu_op;    o.dmem_req = bus.dmem_req;
        o.dmem_we = bus.dmem_we;    o.rf_we = rf_we;      o.wb_sel = wb_sel;
        o.pc_we = pc_we;            o.pc_sel = pc_sel;    o.retire = retire;
        o.trap = trap;              o.cause = trap_cause;
        return o;
    endfunction

    always @(negedge clk) begin
        obs_t got;
        if (exp_valid) begin
            got = sample();
            n_tests++;
            if (got !== exp_cur) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", exp_name, got, exp_cur);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) since_retire = 0;
        else begin
            since_retire++;
            if (retire === 1'b1) begin
                last_cpi = since_retire;
                since_retire = 0;
            end
        end
    end

    task automatic check_int(input string nm, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    task automatic check_obs(input string nm, input obs_t got, input obs_t expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, expv);
        end
    endtask

    function automatic void model_decode(input logic [31:0] i, output int cls,
                                         output logic [2:0] imm, output logic [3:0] op);
        logic [2:0] f3;
        f3 = i[14:12];
        case (i[6:0])
            7'b0110011: cls = (i[31:25] == 7'h00 || (i[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? C_R : C_ILL;
            7'b0010011: cls = C_I;
            7'b0000011: cls = (f3 == 3'd2) ? C_LW : C_ILL;
            7'b0100011: cls = (f3 == 3'd2) ? C_SW : C_ILL;
            7'b1100011: cls = (f3 <= 3'd1) ? C_BR : C_ILL;
            default:    cls = C_ILL;
        endcase
        case (f3)
            3'd0: op = (cls == C_R && i[30]) ? 4'd1 : 4'd0;
            3'd1: op = 4'd5;
            3'd2: op = 4'd8;
            3'd3: op = 4'd9;
            3'd4: op = 4'd4;
            3'd5: op = i[30] ? 4'd7 : 4'd6;
            3'd6: op = 4'd3;
            default: op = 4'd2;
        endcase
        if (cls == C_LW || cls == C_SW || cls == C_ILL) op = 4'd0;
        if (cls == C_BR) op = 4'd1;
        imm = (cls == C_I || cls == C_LW) ? 3'd1 : (cls == C_SW) ? 3'd2 : (cls == C_BR) ? 3'd3 : 3'd0;
    endfunction

    task automatic cyc(input obs_t e, input logic ir, input logic dr, input string nm);
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        exp_cur   = e;
        exp_name  = nm;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic trap_tail(input logic [1:0] cause, input string nm);
        obs_t e;
        for (int k = 0; k < 4; k++) begin
            e = '0; e.trap = 1'b1; e.cause = cause;
            cyc(e, 1'b1, 1'b1, {nm, " trap"});
        end
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        rst_n = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.inst = 32'h0;
        #1;
        check_obs("reset outputs", sample(), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc('0, 1'b1, 1'b0, "idle");
    endtask

    // Expected trace of one instruction from its class, the memory wait counts and alu_zero
    task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait,
                             input logic z, input string nm);
        int cls;
        logic [2:0] imm;
        logic [3:0] op;
        obs_t e, base;
        model_decode(ins, cls, imm, op);
        alu_zero = z;
        for (int k = 0; k < iwait && k < TMO; k++) begin
            e = '0; e.imem_req = 1'b1;
            cyc(e, 1'b0, 1'b0, {nm, " fetch-wait"});
        end
        if (iwait >= TMO) begin
            trap_tail(2'b10, nm);
            return;
        end
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        cyc(e, 1'b1, 1'b0, {nm, " fetch"});
        bus.inst = ins;
        base = '0; base.imm_type = imm; base.alu_op = op;
        cyc(base, 1'b1, 1'b0, {nm, " decode"});
        if (cls == C_ILL) begin
            trap_tail(2'b01, nm);
            return;
        end
        e = base;
        e.alu_src_b = (cls == C_I || cls == C_LW || cls == C_SW);
        if (cls == C_BR) begin
            e.pc_we = 1'b1; e.retire = 1'b1;
            e.pc_sel = ins[12] ? !z : z;
        end
        cyc(e, 1'b1, 1'b0, {nm, " exec"});
        if (cls == C_BR) return;
        if (cls == C_LW || cls == C_SW) begin
            for (int k = 0; k < dwait && k < TMO; k++) begin
                e = base; e.dmem_req = 1'b1; e.dmem_we = (cls == C_SW);
                cyc(e, 1'b1, 1'b0, {nm, " mem-wait"});
            end
            if (dwait >= TMO) begin
                trap_tail(2'b11, nm);
                return;
            end
            e = base; e.dmem_req = 1'b1; e.dmem_we = (cls == C_SW);
            if (cls == C_SW) begin
                e.pc_we = 1'b1; e.retire = 1'b1;
            end
            cyc(e, 1'b1, 1'b1, {nm, " mem"});
            if (cls == C_SW) return;
        end
        e = base; e.rf_we = 1'b1; e.wb_sel = (cls == C_LW); e.pc_we = 1'b1; e.retire = 1'b1;
        cyc(e, 1'b1, 1'b0, {nm, " wb"});
    endtask

    initial begin
        obs_t e;
        bus.inst = 32'h0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0, "add");
        check_int("add cycles incl idle", last_cpi, 5);
        run_instr(32'h0000A183, 0, 3, 1'b0, "lw");
        check_int("lw cycles", last_cpi, 8);
        run_instr(32'h00208463, 0, 0, 1'b1, "beq taken");
        check_int("beq cycles", last_cpi, 3);
        run_instr(32'h00208463, 0, 0, 1'b0, "beq not taken");
        run_instr(32'h0020A223, 0, 0, 1'b0, "sw");
        check_int("sw cycles", last_cpi, 4);
        run_instr(32'h402081B3, 2, 0, 1'b0, "sub");
        check_int("sub cycles", last_cpi, 6);
        run_instr(32'h4040D193, 0, 0, 1'b1, "srai");
        run_instr(32'h00209463, 0, 0, 1'b0, "bne taken");
        run_instr(32'h0020F1B3, 0, 0, 1'b0, "and");
        run_instr(32'h002081B3, TMO - 1, 0, 1'b0, "fetch ready on last cycle");
        check_int("late fetch cycles", last_cpi, 4 + TMO - 1);
        run_instr(32'h0000A183, 0, TMO - 1, 1'b0, "mem ready on last cycle");
        check_int("late mem cycles", last_cpi, 5 + TMO - 1);

        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, "illegal ones");
        check_int("illegal trap flag", {30'd0, trap_cause} + (trap ? 4 : 0), 5);
        do_reset();
        run_instr(32'h4020F1B3, 0, 0, 1'b0, "illegal funct7");
        do_reset();
        run_instr(32'h0020C463, 0, 0, 1'b0, "illegal blt");
        do_reset();
        run_instr(32'h002081B3, 100, 0, 1'b0, "imem timeout");
        check_int("imem timeout cause", trap_cause, 2);
        do_reset();
        run_instr(32'h0020A223, 0, 100, 1'b0, "dmem timeout");
        do_reset();

        // Reset dropped while a store is completing must kill the strobe at once
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        cyc(e, 1'b1, 1'b0, "async fetch");
        bus.inst = 32'h0020A223;
        e = '0; e.imm_type = 3'd2;
        cyc(e, 1'b1, 1'b0, "async decode");
        e.alu_src_b = 1'b1;
        cyc(e, 1'b1, 1'b0, "async exec");
        exp_valid = 1'b0;
        bus.dmem_ready = 1'b1;
        #1;
        check_int("async pre-reset pc_we", int'(pc_we), 1);
        rst_n = 1'b0;
        #1;
        check_obs("async reset outputs", sample(), '0);
        do_reset();
        run_instr(32'h002081B3, 0, 0, 1'b0, "add after reset");
        exp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the Scpu core. It sequences instruction fetch, decode, execute, memory and writeback for the RV32I subset the datapath implements. It drives the immediate-type select consumed by the instruction decoder, the ALU/regfile/PC enables and the memory request handshakes. It also traps on illegal opcodes and on memory timeouts.

## Interface
- TIMEOUT, 16: max cycles a memory request may wait for ready before trapping (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  current instruction register contents (stable from DECODE until next FETCH completes)
- alu_zero  in  1  ALU result == 0
- imem_ready  in  1  instruction memory has inst data this cycle
- dmem_ready  in  1  data memory access completes this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load instruction register
- imm_type  out  3  immediate select to decoder: 000 none, 001 I, 010 S, 011 B
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (valid with dmem_req)
- rf_we  out  1  register file write
- wb_sel  out  1  0 = ALU result, 1 = load data
- pc_we  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = PC+imm
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky; FSM halted
- trap_cause  out  2  00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Outputs are Moore-style decodes of state plus inst. Every output is 0 in IDLE and TRAP, apart from the trap and trap_cause registers.
- Supported instructions:
  - opcode 0110011 (R): funct7 0000000 or 0100000 (SUB/SRA only)
  - 0010011 (I-ALU): SRAI takes inst[30]
  - 0000011 with funct3 010 (LW)
  - 0100011 with funct3 010 (SW)
  - 1100011 with funct3 000/001 (BEQ/BNE)
  - All else is illegal.
- imm_type: I for I-ALU/LW, S for SW, B for branch, 000 for R. Forced 000 in IDLE/FETCH/TRAP.
- alu_op mapping:
  - funct3 000 gives ADD, or SUB when R-type with inst[30]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by inst[30], 110 OR, 111 AND.
  - LW/SW use ADD. Branch uses SUB.
- IDLE: entered on reset; unconditionally goes to FETCH next cycle.
- FETCH: imem_req=1. When imem_ready=1, ir_we=1 in that same cycle, then go to DECODE.
- DECODE (1 cycle): if illegal, go to TRAP with cause 01; else go to EXEC.
- EXEC (1 cycle): alu_src_b=1 for I-ALU/LW/SW.
  - Branch: pc_we=1, pc_sel = (BEQ ? alu_zero : !alu_zero), retire=1, next FETCH.
  - LW/SW: next MEM.
  - R/I-ALU: next WB.
- MEM: dmem_req=1, dmem_we=1 for SW.
  - On dmem_ready with LW: go to WB.
  - On dmem_ready with SW: pc_we=1, pc_sel=0, retire=1, next FETCH.
- WB (1 cycle): rf_we=1, wb_sel=1 for LW, pc_we=1, pc_sel=0, retire=1, next FETCH.
- Timeout counter:
  - Counts cycles in FETCH/MEM with ready low, and clears on state change.
  - When it reaches TIMEOUT with ready still low, go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - Ready arriving on the TIMEOUT-th cycle wins; no trap.
- TRAP: absorbing; only rst_n exits. No pc_we, rf_we, dmem_req or retire is ever issued for the faulting instruction.

## Timing
- Reset (async, rst_n low): state IDLE, counter 0, trap=0, trap_cause=00, all outputs 0.
- First imem_req is on the 2nd rising edge after rst_n rises (IDLE lasts one cycle).
- Cycles per instruction with zero-wait memory (ready high on the first request cycle):
  - Branch 3
  - R/I-ALU 4
  - SW 4
  - LW 5
- Each wait cycle adds 1.
- retire and pc_we are coincident, exactly one cycle each per instruction.
- The request stays asserted until ready, and deasserts the cycle after the ready handshake.
- Reset asserted mid-instruction: outputs go to 0 immediately (asynchronously). No partial write is completed.

## Test plan
- Reset then ADD x3,x1,x2 (0x002081B3), imem_ready=1 always → imem_req in cycle 2; then DECODE, EXEC, WB. WB shows rf_we=1, pc_we=1, pc_sel=0, retire=1, alu_op=0, imm_type=000.
- LW (0x0000A183) with dmem_ready delayed 3 cycles → dmem_req held 4 cycles, dmem_we=0, imm_type=001. WB has wb_sel=1, rf_we=1. Total 8 cycles.
- BEQ (0x00208463):
  - alu_zero=1 in EXEC → pc_we=1, pc_sel=1, imm_type=011, 3 cycles total.
  - Repeat with alu_zero=0 → pc_sel=0.
- SW (0x0020A223) → imm_type=010 and alu_src_b=1 in EXEC. MEM has dmem_we=1 and pc_we+retire on dmem_ready. rf_we never asserts.
- inst=0xFFFFFFFF → DECODE goes to TRAP, trap=1, trap_cause=01. No pc_we/retire afterwards; cleared only by rst_n.
- Timeout, TIMEOUT=16:
  - imem_ready held 0 → trap_cause=10 after 16 request cycles.
  - imem_ready=1 on exactly the 16th cycle → normal DECODE, no trap.
